// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage load/store engine: store/load type codes,
// FSM states and helpers for alignment checking and byte-strobe forming.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MEM_SB   = 2'b00;
  localparam logic [1:0] MEM_SH   = 2'b01;
  localparam logic [1:0] MEM_SW   = 2'b10;
  localparam logic [1:0] MEM_NONE = 2'b11;

  localparam logic [2:0] MEM_LB  = 3'b000;
  localparam logic [2:0] MEM_LH  = 3'b001;
  localparam logic [2:0] MEM_LW  = 3'b010;
  localparam logic [2:0] MEM_LBU = 3'b011;
  localparam logic [2:0] MEM_LHU = 3'b100;
  localparam logic [2:0] MEM_RAW = 3'b111;

  // Halfwords need even addresses; words (and raw/undefined loads) need word alignment.
  function automatic logic is_misaligned(input logic is_store, input logic [1:0] store_type,
                                         input logic [2:0] load_type, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    if (is_store) begin
      case (store_type)
        MEM_SH:  bad = offset[0];
        MEM_SW:  bad = (offset != 2'b00);
        default: bad = 1'b0;
      endcase
    end else begin
      case (load_type)
        MEM_LB, MEM_LBU: bad = 1'b0;
        MEM_LH, MEM_LHU: bad = offset[0];
        default:         bad = (offset != 2'b00);
      endcase
    end
    return bad;
  endfunction

  // Byte enables for a store of the given width at the given byte offset.
  function automatic logic [3:0] store_strobe(input logic [1:0] store_type, input logic [1:0] offset);
    logic [3:0] strb;
    case (store_type)
      MEM_SB:  strb = 4'b0001 << offset;
      MEM_SH:  strb = offset[1] ? 4'b1100 : 4'b0011;
      MEM_SW:  strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// Combinational load lane select and sign/zero extension; usable by forwarding logic too.
module load_extender
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_type,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane, then extend according to the load type.
  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (load_type)
      MEM_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      MEM_LH:  data = {{16{half_sel[15]}}, half_sel};
      MEM_LBU: data = {24'h000000, byte_sel};
      MEM_LHU: data = {16'h0000, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: single-outstanding valid/ready bus master with
// store forming, load extension, misalignment drop and optional bus timeout.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_write,
  input  logic        wb_load,
  input  logic [1:0]  mem_store_type,
  input  logic [2:0]  mem_load_type,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        mem_stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        bus_err
);

  localparam int CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int CNT_MAX = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1;

  state_t             state, state_next;
  logic               store_en, access, bad_align, accept, timeout_hit;
  logic               lat_load, err_flag;
  logic [1:0]         lat_off;
  logic [2:0]         lat_type;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        ext_data;
  logic [31:0]        wdata_form;

  // A store with a real width wins over a simultaneous load.
  assign store_en    = mem_write & (mem_store_type != MEM_NONE);
  assign access      = req_valid & (store_en | wb_load);
  assign bad_align   = is_misaligned(store_en, mem_store_type, mem_load_type, addr[1:0]);
  assign accept      = (state == ST_IDLE) & access & ~bad_align;
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (state == ST_REQ) && !bus_ready &&
                       (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Lane-replicated write data for the requested store width.
  always_comb begin
    case (mem_store_type)
      MEM_SB:  wdata_form = {4{store_data[7:0]}};
      MEM_SH:  wdata_form = {2{store_data[15:0]}};
      default: wdata_form = store_data;
    endcase
  end

  load_extender u_load_extender (
    .rdata     (bus_rdata),
    .offset    (lat_off),
    .load_type (lat_type),
    .data      (ext_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic: accept in IDLE, wait in REQ, always leave DONE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_REQ;
      ST_REQ:  if (bus_ready || timeout_hit) state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Per-state outputs; the stall is forced low while reset is applied.
  always_comb begin
    bus_req    = (state == ST_REQ);
    mem_stall  = ~rst & (accept | (state == ST_REQ));
    load_valid = (state == ST_DONE) & lat_load;
    bus_err    = (state == ST_DONE) & err_flag;
  end

  // Latch the access on acceptance and keep it stable while the request is up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_wstrb <= 4'h0;
      bus_wdata <= 32'h0;
      lat_load  <= 1'b0;
      lat_off   <= 2'b00;
      lat_type  <= 3'b000;
    end else if (accept) begin
      bus_we    <= store_en;
      bus_addr  <= {addr[31:2], 2'b00};
      bus_wstrb <= store_en ? store_strobe(mem_store_type, addr[1:0]) : 4'b0000;
      bus_wdata <= store_en ? wdata_form : 32'h0;
      lat_load  <= ~store_en;
      lat_off   <= addr[1:0];
      lat_type  <= mem_load_type;
    end
  end

  // Timeout counter, completion data, error flag and misalignment pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      load_data  <= 32'h0;
      err_flag   <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      if (accept)
        cnt <= '0;
      else if (state == ST_REQ && cnt != CNT_W'(CNT_MAX))
        cnt <= cnt + 1'b1;
      if (state == ST_REQ && bus_ready && lat_load)
        load_data <= ext_data;
      else if (timeout_hit)
        load_data <= 32'h0;
      err_flag   <= timeout_hit;
      misaligned <= (state == ST_IDLE) & access & bad_align;
    end
  end

endmodule
